// File: rtl/booth_multiplier_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract-and-shift step per clock.
// The product is packed {HI, LO} into result and presented with a start/busy/done handshake.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; result holds the last product
//  RUN    | BITS Booth steps in progress; busy=1, start ignored
//  DONE   | one-cycle done pulse; start here launches the next operation
module booth_multiplier_seq #(
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [BITS-1:0]   multiplicand,
  input  logic [BITS-1:0]   multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] result
);

  localparam int CW = $clog2(BITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [BITS:0]     a_q,      a_d;
  logic [BITS:0]     mx_q,     mx_d;
  logic [BITS-1:0]   q_q,      q_d;
  logic              q1_q,     q1_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [2*BITS-1:0] result_q, result_d;

  logic [BITS:0]     sum;
  logic              load;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    mx_d     = mx_q;
    q_d      = q_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    // Booth recoding of the pair {Q[0], q_1}
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + mx_q;
      2'b10:   sum = a_q - mx_q;
      default: sum = a_q;
    endcase

    load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        a_d   = {sum[BITS], sum[BITS:1]};
        q_d   = {sum[0], q_q[BITS-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = {a_d[BITS-1:0], q_d};
        end
      end
      S_DONE: begin
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      a_d   = '0;
      mx_d  = {multiplicand[BITS-1], multiplicand};
      q_d   = multiplier;
      q1_d  = 1'b0;
      cnt_d = CW'(BITS);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      mx_q     <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      mx_q     <= mx_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq (BITS=32): directed cases plus random operands,
// checked against a plain signed-multiply reference.
module tb_booth_multiplier_seq;

  localparam int BITS = 32;

  logic              clk;
  logic              clr;
  logic              start;
  logic [BITS-1:0]   multiplicand;
  logic [BITS-1:0]   multiplier;
  logic              busy;
  logic              done;
  logic [2*BITS-1:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  booth_multiplier_seq #(.BITS(BITS)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge; returns in the first RUN cycle.
  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    step();
    start        = 1'b0;
  endtask

  // Runs from the current cycle until done (bounded); counts busy and total cycles.
  task automatic wait_done(input logic [63:0] held, output int nbusy, output int ncyc,
                           output bit stable);
    nbusy  = 0;
    ncyc   = 0;
    stable = 1'b1;
    while (done !== 1'b1 && ncyc < 100) begin
      if (busy === 1'b1) nbusy++;
      if (result !== held) stable = 1'b0;
      ncyc++;
      step();
    end
  endtask

  task automatic full_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] held);
    int nb, nc;
    bit st;
    start_op(m, q);
    wait_done(held, nb, nc, st);
    chk({tag, "_done"},   64'(done), 64'd1);
    chk({tag, "_busy_n"}, 64'(nb), 64'd32);
    chk({tag, "_cyc_n"},  64'(nc), 64'd32);
    chk({tag, "_held"},   64'(st), 64'd1);
    chk({tag, "_result"}, result, ref_mul(m, q));
    step();
    chk({tag, "_pulse"},  64'(done), 64'd0);
    chk({tag, "_idle"},   64'(busy), 64'd0);
    chk({tag, "_keep"},   result, ref_mul(m, q));
  endtask

  initial begin
    logic [63:0] last;
    int nb, nc;
    bit st;
    bit seen_done;
    logic [31:0] rm, rq;

    clr          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) step();
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    clr = 1'b1;
    step();

    full_op("t1_7x3", 32'd7, 32'd3, 64'd0);
    chk("t1_const", result, 64'h0000_0000_0000_0015);
    full_op("t2_m7x3", 32'hFFFF_FFF9, 32'd3, 64'h15);
    chk("t2_const", result, 64'hFFFF_FFFF_FFFF_FFEB);
    full_op("t2_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t2b_const", result, 64'h0000_0000_0000_0001);
    full_op("t3_minxmin", 32'h8000_0000, 32'h8000_0000, 64'h1);
    chk("t3_const", result, 64'h4000_0000_0000_0000);
    full_op("t3_minx1", 32'h8000_0000, 32'd1, 64'h4000_0000_0000_0000);
    chk("t3b_const", result, 64'hFFFF_FFFF_8000_0000);
    full_op("t3_0x0", 32'd0, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    last = 64'd0;

    // start pulsed mid-RUN is ignored
    start_op(32'd5, 32'd6);
    repeat (9) step();
    chk("t4_busy10", 64'(busy), 64'd1);
    start        = 1'b1;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    step();
    start = 1'b0;
    wait_done(last, nb, nc, st);
    chk("t4_done",    64'(done), 64'd1);
    chk("t4_latency", 64'(10 + nc), 64'd32);
    chk("t4_result",  result, 64'd30);
    step();
    chk("t4_single",  64'(done), 64'd0);
    chk("t4_idle",    64'(busy), 64'd0);
    last = 64'd30;

    // asynchronous clear mid-RUN
    start_op(32'd5, 32'd6);
    repeat (15) step();
    chk("t5_busy16", 64'(busy), 64'd1);
    #2 clr = 1'b0;
    #1;
    chk("t5_clr_busy",   64'(busy), 64'd0);
    chk("t5_clr_done",   64'(done), 64'd0);
    chk("t5_clr_result", result, 64'd0);
    @(posedge clk);
    #1 clr = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      step();
    end
    chk("t5_no_done", 64'(seen_done), 64'd0);
    full_op("t5_2x2", 32'd2, 32'd2, 64'd0);
    last = 64'd4;

    // back-to-back: new start in the DONE cycle
    start_op(32'd5, 32'd6);
    wait_done(last, nb, nc, st);
    chk("t6_done1",   64'(done), 64'd1);
    chk("t6_result1", result, 64'd30);
    start_op(32'd12, 32'hFFFF_FFFE);
    chk("t6_busy_now", 64'(busy), 64'd1);
    chk("t6_done_off", 64'(done), 64'd0);
    chk("t6_hold30",   result, 64'd30);
    wait_done(64'd30, nb, nc, st);
    chk("t6_busy_n", 64'(nb), 64'd32);
    chk("t6_cyc_n",  64'(nc), 64'd32);
    chk("t6_held",   64'(st), 64'd1);
    chk("t6_done2",  64'(done), 64'd1);
    chk("t6_result2", result, 64'hFFFF_FFFF_FFFF_FFE8);
    step();
    last = 64'hFFFF_FFFF_FFFF_FFE8;

    for (int i = 0; i < 8; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i == 0) rm = 32'h7FFF_FFFF;
      if (i == 1) rq = 32'h8000_0000;
      full_op($sformatf("rnd%0d", i), rm, rq, last);
      last = ref_mul(rm, rq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
